mem_write_buffer: RTL

//  Store buffer between the CPU MEM stage (addrData/dataOut/memWE) and a slow data RAM write port.
//  - Queues stores in a FIFO and drains them to RAM over a req/ack handshake, so the CPU never waits on writes.
//  - Loads read the RAM read port combinationally, with store-to-load forwarding from pending entries.

---
 rtl/mem_write_buffer.sv | 96 +++++++++
 1 files changed

// File: rtl/mem_write_buffer.sv
// Store buffer between the CPU MEM stage and a slow RAM write port, with optional
// store-to-load forwarding enabled by defining WBUF_FORWARD_EN.
module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     cpu_we,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic [ADDR_W-1:0]        ram_raddr,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     fwd_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic              push;
  logic              pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign mem_req   = !empty;
  assign mem_addr  = addrMem[headPtr];
  assign mem_wdata = dataMem[headPtr];
  assign ram_raddr = cpu_addr;

  assign pop  = mem_req && mem_ack;
  assign push = cpu_we && (!full || pop);

  // Entry storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[tailPtr] <= cpu_addr;
      dataMem[tailPtr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (cpu_we && !push) overflow <= 1'b1;
    end
  end

`ifdef WBUF_FORWARD_EN
  logic              fwdHit;
  logic [DATA_W-1:0] fwdData;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = ram_rdata;
    if (!cpu_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count) &&
            (addrMem[headPtr + PTR_W'(i)][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
          fwdHit  = 1'b1;
          fwdData = dataMem[headPtr + PTR_W'(i)];
        end
      end
    end
  end

  assign fwd_hit   = fwdHit;
  assign cpu_rdata = fwdData;
`else
  assign fwd_hit   = 1'b0;
  assign cpu_rdata = ram_rdata;
`endif

endmodule
